program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, width of the host byte address.
REQ-002 SHALL have parameter SIZE_WIDTH, default 16, width of the line count.
REQ-003 SHALL have parameter IMEM_ADDR_WIDTH, default 14, word address width of the instruction memory.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port go, input, 1, single-cycle start pulse from the MMIO block.
REQ-007 SHALL have port start_addr, input, ADDR_WIDTH, host byte address of the program image; it is 64-byte aligned and bits [5:0] are ignored.
REQ-008 SHALL have port num_lines, input, SIZE_WIDTH, number of 512-bit cache lines to load.
REQ-009 SHALL have port soft_reset, input, 1, level software reset from the MMIO block.
REQ-010 SHALL have port unhalt, input, 1, level processor-release request from the MMIO block.
REQ-011 SHALL have port dma_rd_addr, output, ADDR_WIDTH-6, cache-line address of the read request.
REQ-012 SHALL have port dma_rd_en, output, 1, read request strobe.
REQ-013 SHALL have port dma_rd_full, input, 1, request backpressure; a request is accepted on any cycle with dma_rd_en=1 and dma_rd_full=0.
REQ-014 SHALL have port dma_rd_valid, input, 1, read response valid.
REQ-015 SHALL have port dma_rd_data, input, 512, read response line.
REQ-016 SHALL have port imem_wr_en, output, 1, instruction memory write strobe.
REQ-017 SHALL have port imem_wr_addr, output, IMEM_ADDR_WIDTH, instruction memory word address.
REQ-018 SHALL have port imem_wr_data, output, 32, instruction word.
REQ-019 SHALL have port cpu_rst, output, 1, processor held in reset while high.
REQ-020 SHALL have port done, output, 1, program load complete.

Function
REQ-021 SHALL implement the states IDLE, REQ, WAIT, WRITE, DONE and RUN, with at most one read outstanding.
REQ-022 SHALL, in IDLE, on go=1 latch start_addr[ADDR_WIDTH-1:6] as the base and num_lines, clear the line index and done, and enter REQ; if num_lines=0 it SHALL enter DONE instead.
REQ-023 SHALL, in REQ, hold dma_rd_en=1 with dma_rd_addr = base + line index (modulo 2^(ADDR_WIDTH-6)), and enter WAIT on the accepting cycle.
REQ-024 SHALL, in WAIT, on dma_rd_valid=1 capture dma_rd_data into a line buffer and enter WRITE the next cycle.
REQ-025 SHALL, in WRITE, issue 16 consecutive imem writes, one per cycle, where write k (0..15) carries data = line[32k+31:32k] and addr = line index*16 + k, truncated to IMEM_ADDR_WIDTH (wraps).
REQ-026 SHALL, after write 15, increment the line index and enter REQ if the index is below num_lines, else enter DONE.
REQ-027 SHALL, in DONE, hold done=1, and on unhalt=1 enter RUN on the next cycle.
REQ-028 SHALL, in RUN, drive cpu_rst=0 and hold done=1.
REQ-029 SHALL drive cpu_rst=1 in every state other than RUN.
REQ-030 SHALL ignore go in every state other than IDLE.
REQ-031 SHALL ignore unhalt in every state other than DONE; an unhalt level already high on entry to DONE moves the block to RUN on the next cycle.
REQ-032 SHALL ignore dma_rd_valid outside WAIT; a stale response after an abort is dropped.
REQ-033 SHALL treat soft_reset=1 as highest priority in any state: enter IDLE the next cycle, deassert dma_rd_en and imem_wr_en, clear done, and set cpu_rst=1; while soft_reset stays high the block SHALL remain in IDLE and ignore go.
REQ-034 SHALL, when go and soft_reset occur in the same cycle, let soft_reset win and not start a load.
REQ-035 SHALL drive dma_rd_en only in REQ and imem_wr_en only in WRITE.
REQ-036 SHALL register all outputs.

Reset
REQ-037 SHALL, while rst=1, asynchronously enter IDLE with dma_rd_en=0, imem_wr_en=0, done=0, cpu_rst=1, all address and data outputs 0, line index 0 and line buffer 0.
REQ-038 SHALL begin normal operation on the first rising clk edge after rst falls.

Verification
REQ-039 Single line: start_addr=0x1000, num_lines=1, go; response word k = k+0xA0 -> one request with dma_rd_addr=0x40, then 16 writes to addr 0..15 with data 0xA0..0xAF, then done=1 and cpu_rst stays 1.
REQ-040 Backpressure: num_lines=3, dma_rd_full=1 for 5 cycles on the second request -> exactly 3 accepted requests (addr base, base+1, base+2), 48 writes, imem addr 0..47.
REQ-041 Zero length: num_lines=0, go -> no requests, done=1 one cycle after go.
REQ-042 Release: after done, unhalt=1 -> cpu_rst=0 next cycle; unhalt pulsed during WRITE -> no effect, cpu_rst stays 1.
REQ-043 Abort: soft_reset=1 during WAIT and a response arriving afterwards -> no imem writes, done=0, state IDLE; a subsequent go reloads from line 0.
REQ-044 Wrap: IMEM_ADDR_WIDTH=4, num_lines=2 -> the second line writes to addr 0..15 again.

Source files
------------

// File: rtl/program_loader.sv
// Loads a program image from host memory into the instruction memory one cache line at a time,
// then holds the processor in reset until software releases it.
module program_loader #(
  parameter int ADDR_WIDTH      = 64,
  parameter int SIZE_WIDTH      = 16,
  parameter int IMEM_ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [ADDR_WIDTH-1:0]      start_addr,
  input  logic [SIZE_WIDTH-1:0]      num_lines,
  input  logic                       soft_reset,
  input  logic                       unhalt,
  output logic [ADDR_WIDTH-7:0]      dma_rd_addr,
  output logic                       dma_rd_en,
  input  logic                       dma_rd_full,
  input  logic                       dma_rd_valid,
  input  logic [511:0]               dma_rd_data,
  output logic                       imem_wr_en,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_wr_addr,
  output logic [31:0]                imem_wr_data,
  output logic                       cpu_rst,
  output logic                       done
);
  localparam int LW = ADDR_WIDTH - 6;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, WRITE, DONE, RUN} state_t;

  state_t                state, state_n;
  logic [LW-1:0]         base, base_n;
  logic [SIZE_WIDTH-1:0] nlines, nlines_n, idx, idx_n, idx_inc;
  logic [3:0]            wcnt, wcnt_n;
  logic [511:0]          line, line_n;
  logic [LW-1:0]         rd_addr_n;
  logic [IMEM_ADDR_WIDTH-1:0] wr_addr_n;
  logic [31:0]           wr_data_n;
  logic                  unused_lsb;

  // Line address bits below the 64-byte boundary carry no information.
  assign unused_lsb = ^start_addr[5:0];

  always_comb begin
    state_n  = state;
    base_n   = base;
    nlines_n = nlines;
    idx_n    = idx;
    wcnt_n   = wcnt;
    line_n   = line;
    idx_inc  = idx + SIZE_WIDTH'(1);
    if (soft_reset) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (go) begin
          base_n   = start_addr[ADDR_WIDTH-1:6];
          nlines_n = num_lines;
          idx_n    = '0;
          wcnt_n   = '0;
          state_n  = (num_lines == '0) ? DONE : REQ;
        end
        REQ:  if (!dma_rd_full) state_n = WAIT;
        WAIT: if (dma_rd_valid) begin
          line_n  = dma_rd_data;
          wcnt_n  = '0;
          state_n = WRITE;
        end
        WRITE: begin
          wcnt_n = wcnt + 4'd1;
          if (wcnt == 4'd15) begin
            idx_n   = idx_inc;
            state_n = (idx_inc < nlines) ? REQ : DONE;
          end
        end
        DONE: if (unhalt) state_n = RUN;
        RUN:  state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
    // Outputs are registered from next-state values so they line up with the state they belong to.
    rd_addr_n = base_n + LW'(idx_n);
    wr_addr_n = IMEM_ADDR_WIDTH'({idx_n, wcnt_n});
    wr_data_n = line_n[{wcnt_n, 5'd0} +: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      nlines       <= '0;
      idx          <= '0;
      wcnt         <= '0;
      line         <= '0;
      dma_rd_addr  <= '0;
      dma_rd_en    <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_rst      <= 1'b1;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      base         <= base_n;
      nlines       <= nlines_n;
      idx          <= idx_n;
      wcnt         <= wcnt_n;
      line         <= line_n;
      dma_rd_addr  <= rd_addr_n;
      dma_rd_en    <= (state_n == REQ);
      imem_wr_en   <= (state_n == WRITE);
      imem_wr_addr <= wr_addr_n;
      imem_wr_data <= wr_data_n;
      cpu_rst      <= (state_n != RUN);
      done         <= (state_n == DONE) || (state_n == RUN);
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus queues expected reads/writes, a monitor checks them.
module tb_program_loader;
  localparam int LW = 58;

  logic clk = 1'b0;
  logic rst = 1'b1, go = 1'b0, soft_reset = 1'b0, unhalt = 1'b0;
  logic [63:0] start_addr = '0;
  logic [15:0] num_lines = '0;
  logic dma_rd_full = 1'b0, dma_rd_valid = 1'b0;
  logic [511:0] dma_rd_data = '0;
  logic [LW-1:0] dma_rd_addr, w_rd_addr;
  logic dma_rd_en, w_rd_en, imem_wr_en, w_wr_en, cpu_rst, w_cpu_rst, done, w_done;
  logic [13:0] imem_wr_addr;
  logic [3:0]  w_wr_addr;
  logic [31:0] imem_wr_data, w_wr_data;

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst(rst), .go(go), .start_addr(start_addr), .num_lines(num_lines),
    .soft_reset(soft_reset), .unhalt(unhalt), .dma_rd_addr(dma_rd_addr), .dma_rd_en(dma_rd_en),
    .dma_rd_full(dma_rd_full), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
    .cpu_rst(cpu_rst), .done(done));

  // Narrow instruction memory copy: same stimulus, addresses must wrap every 16 words.
  program_loader #(.IMEM_ADDR_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .go(go), .start_addr(start_addr), .num_lines(num_lines),
    .soft_reset(soft_reset), .unhalt(unhalt), .dma_rd_addr(w_rd_addr), .dma_rd_en(w_rd_en),
    .dma_rd_full(dma_rd_full), .dma_rd_valid(dma_rd_valid), .dma_rd_data(dma_rd_data),
    .imem_wr_en(w_wr_en), .imem_wr_addr(w_wr_addr), .imem_wr_data(w_wr_data),
    .cpu_rst(w_cpu_rst), .done(w_done));

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;
  logic [LW-1:0] exp_req[$];
  wr_t           exp_wr[$];
  int checks = 0, errors = 0;
  int req_num = 0, rsp_cd = 0, rsp_seq = 0, stall_n = 0;
  int rsp_delay = 2, bp_req = -1, bp_len = 0;
  logic [31:0] seed = 32'hA0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_line(input int n);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = seed + 32'(n*256 + k);
    return l;
  endfunction

  function automatic logic [31:0] exp_word(input int n, input int k);
    return seed + 32'(n*256 + k);
  endfunction

  // Host memory model: optional backpressure on one request, response rsp_delay cycles after accept.
  always @(negedge clk) begin
    dma_rd_valid = 1'b0;
    if (rsp_cd > 0) begin
      rsp_cd--;
      if (rsp_cd == 0) begin
        dma_rd_valid = 1'b1;
        dma_rd_data  = mk_line(rsp_seq);
        rsp_seq++;
      end
    end
    dma_rd_full = 1'b0;
    if (dma_rd_en && req_num == bp_req && stall_n < bp_len) begin
      dma_rd_full = 1'b1;
      stall_n++;
    end
    if (dma_rd_en && !dma_rd_full) begin
      req_num++;
      rsp_cd = rsp_delay;
    end
  end

  always @(negedge clk) begin
    logic [LW-1:0] ea;
    wr_t ew;
    #2;
    if (dma_rd_en && !dma_rd_full) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %0h expected none", dma_rd_addr);
      end else begin
        ea = exp_req.pop_front();
        chk("rd_addr", 64'(dma_rd_addr), 64'(ea));
        chk("w_rd_addr", 64'(w_rd_addr), 64'(ea));
      end
    end
    if (imem_wr_en) begin
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h expected none", imem_wr_addr, imem_wr_data);
      end else begin
        ew = exp_wr.pop_front();
        chk("wr_addr", 64'(imem_wr_addr), 64'(ew.a));
        chk("wr_data", 64'(imem_wr_data), 64'(ew.d));
        chk("w_wr_en", 64'(w_wr_en), 64'd1);
        chk("w_wr_addr_wrap", 64'(w_wr_addr), 64'(ew.a[3:0]));
        chk("w_wr_data", 64'(w_wr_data), 64'(ew.d));
      end
    end
  end

  task automatic pulse_go(input logic [63:0] a, input logic [15:0] n);
    @(negedge clk);
    start_addr = a; num_lines = n; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic push_load(input logic [LW-1:0] base, input int lines, input int s0);
    wr_t w;
    for (int n = 0; n < lines; n++) begin
      exp_req.push_back(base + LW'(n));
      for (int k = 0; k < 16; k++) begin
        w.a = 14'(n*16 + k);
        w.d = exp_word(s0 + n, k);
        exp_wr.push_back(w);
      end
    end
  endtask

  task automatic wait_done(input string nm);
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, 64'(done), 64'd1);
    chk({nm, "_w"}, 64'(w_done), 64'd1);
  endtask

  task automatic do_soft_reset();
    @(negedge clk); soft_reset = 1'b1;
    @(negedge clk); soft_reset = 1'b0;
    chk("sr_done", 64'(done), 64'd0);
    chk("sr_cpu_rst", 64'(cpu_rst), 64'd1);
  endtask

  initial begin
    int r0, s0, t;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rd_en", 64'(dma_rd_en), 64'd0);
    chk("rst_wr_en", 64'(imem_wr_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_rd_addr", 64'(dma_rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(imem_wr_addr), 64'd0);
    chk("rst_wr_data", 64'(imem_wr_data), 64'd0);
    rst = 1'b0;

    // Single line at 0x1000 -> line address 0x40, words 0xA0..0xAF
    seed = 32'hA0;
    push_load(58'h40, 1, rsp_seq);
    pulse_go(64'h1000, 16'd1);
    wait_done("t1_done");
    chk("t1_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t1_req_left", 64'(exp_req.size()), 64'd0);
    chk("t1_wr_left", 64'(exp_wr.size()), 64'd0);
    do_soft_reset();

    // Three lines with five stalled cycles on the second request; unhalt during WRITE is ignored
    seed = 32'h1000;
    r0 = req_num;
    bp_req = r0 + 1; bp_len = 5;
    push_load(58'h800, 3, rsp_seq);
    pulse_go(64'h20000, 16'd3);
    for (t = 0; t < 100; t++) begin
      if (imem_wr_en) break;
      @(negedge clk);
    end
    chk("t2_in_write", 64'(imem_wr_en), 64'd1);
    unhalt = 1'b1;
    @(negedge clk); unhalt = 1'b0;
    @(negedge clk);
    chk("t2_unhalt_ignored", 64'(cpu_rst), 64'd1);
    wait_done("t2_done");
    chk("t2_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t2_stalls", 64'(stall_n), 64'd5);
    chk("t2_reqs", 64'(req_num - r0), 64'd3);
    chk("t2_wr_left", 64'(exp_wr.size()), 64'd0);

    // Release from DONE
    @(negedge clk); unhalt = 1'b1;
    @(negedge clk); unhalt = 1'b0;
    chk("t3_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("t3_w_cpu_rst", 64'(w_cpu_rst), 64'd0);
    chk("t3_done", 64'(done), 64'd1);
    do_soft_reset();

    // Zero-length load
    r0 = req_num;
    pulse_go(64'h2000, 16'd0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_reqs", 64'(req_num - r0), 64'd0);
    do_soft_reset();

    // Abort during WAIT; stale response must be dropped
    seed = 32'h5000;
    rsp_delay = 6;
    r0 = req_num;
    exp_req.push_back(58'h1);
    pulse_go(64'h40, 16'd2);
    for (t = 0; t < 50; t++) begin
      if (req_num != r0) break;
      @(negedge clk);
    end
    chk("t5_accepted", 64'(req_num - r0), 64'd1);
    @(negedge clk); soft_reset = 1'b1;
    @(negedge clk); go = 1'b1; start_addr = 64'h40; num_lines = 16'd1;
    @(negedge clk); soft_reset = 1'b0; go = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_rd_en", 64'(dma_rd_en), 64'd0);
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("t5_no_new_req", 64'(req_num - r0), 64'd1);
    chk("t5_stale_rsp_seen", 64'(rsp_seq), 64'(r0 + 1 - bp_len + bp_len));

    // Reload two lines from line 0; the 4-bit copy rewrites addresses 0..15
    rsp_delay = 2;
    s0 = rsp_seq;
    push_load(58'h1, 2, s0);
    pulse_go(64'h40, 16'd2);
    wait_done("t6_done");

    repeat (3) @(negedge clk);
    chk("end_req_left", 64'(exp_req.size()), 64'd0);
    chk("end_wr_left", 64'(exp_wr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
